// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP add/sub unit arbiter.
// Holds the FSM state encoding and the default FP word geometry.
package fp_arb_pkg;

    localparam int FP_W               = 32;   // sign + exponent + mantissa
    localparam int EXP_W              = 8;
    localparam int MANT_W             = 24;   // includes hidden bit
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fp_unit_arbiter_rr.sv
// Combinational rotating-priority arbiter.
// Priority starts just after i_ptr and wraps, so the requester at i_ptr
// itself is considered last.
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Candidate index for each priority slot: (ptr + 1 + slot) mod NREQ.
    logic [IDX_W-1:0] w_cand [NREQ];
    logic             w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(gi + 1);
            // ptr <= NREQ-1 and offset <= NREQ, so one subtraction folds it back.
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NREQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NREQ))
                              : w_sum[IDX_W-1:0];
        end
    endgenerate

    // Pick the first requesting candidate in rotated priority order.
    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[w_cand[k]]) begin
                w_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

    assign o_any = w_found;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign o_grant[gi] = w_found && (o_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one FP add/sub + rounding datapath among
// NREQ requesters, with exactly one operation in flight.
// Optional WAIT-state watchdog enabled by defining FPARB_TIMEOUT_EN.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int W              = FP_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*W-1:0] i_req_opa,
    input  logic [NREQ*W-1:0] i_req_opb,
    input  logic [NREQ-1:0]   i_req_sub,
    output logic              o_unit_start,
    output logic [W-1:0]      o_unit_opa,
    output logic [W-1:0]      o_unit_opb,
    output logic              o_unit_sub,
    input  logic              i_unit_valid,
    input  logic [W-1:0]      i_unit_result,
    input  logic              i_unit_invalid,
    output logic              o_unit_ack,
    output logic [NREQ-1:0]   o_rsp_valid,
    input  logic [NREQ-1:0]   i_rsp_ready,
    output logic [W-1:0]      o_rsp_result,
    output logic              o_rsp_invalid,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int IDX_W = $clog2(NREQ);

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gidx;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic             r_sub;
    logic [W-1:0]     r_result;
    logic             r_invalid;
    logic             r_unit_ack;

    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;
    logic             w_any;
    logic             w_accept;
    logic             w_unit_done;
    logic             w_rsp_done;
    logic             w_timeout;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Grant is only offered in IDLE and never while reset is held.
    assign o_req_ready = (r_state == IDLE && i_rst_n) ? w_grant : '0;
    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_unit_done = (r_state == WAIT) && i_unit_valid;
    assign w_rsp_done  = (r_state == DELIVER) && i_rsp_ready[r_gidx];

`ifdef FPARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout_err;

    // A result arriving on the expiry cycle takes precedence over the timeout.
    assign w_timeout = (r_state == WAIT) && !i_unit_valid
                    && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on entry to WAIT, counts WAIT cycles, sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wd_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    // Without the watchdog, WAIT lasts until the datapath answers.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)                w_state_next = WAIT;
            WAIT:    if (w_unit_done || w_timeout) w_state_next = DELIVER;
            DELIVER: if (w_rsp_done)              w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // State, operand/result capture, ack pulse and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= IDX_W'(NREQ - 1);
            r_gidx     <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_sub      <= 1'b0;
            r_result   <= '0;
            r_invalid  <= 1'b0;
            r_unit_ack <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_unit_ack <= 1'b0;
            if (w_accept) begin
                r_gidx <= w_gidx;
                r_opa  <= i_req_opa[w_gidx*W +: W];
                r_opb  <= i_req_opb[w_gidx*W +: W];
                r_sub  <= i_req_sub[w_gidx];
            end
            if (w_unit_done) begin
                r_result   <= i_unit_result;
                r_invalid  <= i_unit_invalid;
                r_unit_ack <= 1'b1;
            end else if (w_timeout) begin
                r_result   <= '0;
                r_invalid  <= 1'b1;
                r_unit_ack <= 1'b1;
            end
            // Only a delivered result moves the fairness pointer.
            if (w_rsp_done) begin
                r_ptr <= r_gidx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign o_rsp_valid[gi] = (r_state == DELIVER) && (r_gidx == IDX_W'(gi));
        end
    endgenerate

    assign o_unit_start  = (r_state == WAIT);
    assign o_unit_opa    = r_opa;
    assign o_unit_opb    = r_opb;
    assign o_unit_sub    = r_sub;
    assign o_unit_ack    = r_unit_ack;
    assign o_rsp_result  = r_result;
    assign o_rsp_invalid = r_invalid;
    assign o_busy        = (r_state != IDLE);

endmodule
